// File: rtl/loop_activity_monitor.sv
// Passive observer for one HLS block: watches the ap_* handshake and the
// pipelined-loop FSM, and accumulates saturating counters plus sticky status.
module loop_activity_monitor #(
   parameter int STATE_W = 1,
   parameter int CNT_W   = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               ap_start,
   input  logic               ap_ready,
   input  logic               ap_done,
   input  logic               ap_continue,
   input  logic               finish,
   input  logic [STATE_W-1:0] cur_state,
   input  logic [STATE_W-1:0] iter_start_state,
   input  logic [STATE_W-1:0] iter_end_state,
   input  logic [STATE_W-1:0] quit_state,
   input  logic               iter_start_block,
   input  logic               iter_end_block,
   input  logic               quit_block,
   input  logic               iter_start_enable,
   input  logic               iter_end_enable,
   input  logic               quit_enable,
   input  logic               loop_start,
   input  logic               loop_ready,
   input  logic               loop_done,
   input  logic               loop_continue,
   input  logic               quit_at_end,
   output logic               module_busy,
   output logic               loop_active,
   output logic [CNT_W-1:0]   txn_count,
   output logic [CNT_W-1:0]   lat_last,
   output logic [CNT_W-1:0]   lat_max,
   output logic [CNT_W-1:0]   iter_start_count,
   output logic [CNT_W-1:0]   iter_end_count,
   output logic [CNT_W-1:0]   stall_count,
   output logic [CNT_W-1:0]   loop_count,
   output logic [CNT_W-1:0]   inflight,
   output logic               quit_error,
   output logic               finished
);

   typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE_WAIT} mod_state_t;
   typedef enum logic       {L_IDLE, L_ACTIVE}            loop_state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   mod_state_t        mstate, mstate_nxt;
   loop_state_t       lstate, lstate_nxt;
   logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
   logic [CNT_W-1:0]  txn_nxt, lat_last_nxt, lat_max_nxt;
   logic [CNT_W-1:0]  start_nxt, end_nxt, stall_nxt, loop_cnt_nxt, inflight_nxt;
   logic [CNT_W-1:0]  rec_lat;
   logic              rec, quit, quit_match, err_nxt;
   logic              start_ev, end_ev, stall_ev;

   // loop_ready carries no information the monitor needs beyond loop_done
   logic unused_ok;
   assign unused_ok = loop_ready;

   // ---------------- module handshake FSM ----------------
   always_comb begin
      mstate_nxt   = mstate;
      lat_cnt_nxt  = lat_cnt;
      txn_nxt      = txn_count;
      lat_last_nxt = lat_last;
      lat_max_nxt  = lat_max;
      rec          = 1'b0;
      rec_lat      = '0;
      case (mstate)
         M_IDLE: begin
            if (ap_start) begin
               if (ap_done) begin
                  rec     = 1'b1;
                  rec_lat = CNT_ONE;
                  if (ap_continue) txn_nxt    = sat_inc(txn_count);
                  else             mstate_nxt = M_DONE_WAIT;
               end else begin
                  mstate_nxt  = M_BUSY;
                  lat_cnt_nxt = CNT_ONE;
               end
            end
         end
         M_BUSY: begin
            lat_cnt_nxt = sat_inc(lat_cnt);
            if (ap_done) begin
               // latency includes both the start and the done cycle
               rec     = 1'b1;
               rec_lat = sat_inc(lat_cnt);
               if (ap_continue) begin
                  txn_nxt    = sat_inc(txn_count);
                  mstate_nxt = M_IDLE;
               end else begin
                  mstate_nxt = M_DONE_WAIT;
               end
            end
         end
         M_DONE_WAIT: begin
            if (ap_continue) begin
               txn_nxt    = sat_inc(txn_count);
               mstate_nxt = M_IDLE;
            end
         end
         default: mstate_nxt = M_IDLE;
      endcase
      if (rec) begin
         lat_last_nxt = rec_lat;
         if (rec_lat > lat_max) lat_max_nxt = rec_lat;
      end
   end

   // ---------------- iteration events ----------------
   assign start_ev = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
   assign end_ev   = (cur_state == iter_end_state)   & iter_end_enable   & ~iter_end_block;
   assign stall_ev = (cur_state == iter_start_state) & iter_start_enable &  iter_start_block;

   always_comb begin
      start_nxt    = start_ev ? sat_inc(iter_start_count) : iter_start_count;
      end_nxt      = end_ev   ? sat_inc(iter_end_count)   : iter_end_count;
      stall_nxt    = (stall_ev && lstate == L_ACTIVE) ? sat_inc(stall_count) : stall_count;
      inflight_nxt = start_nxt - end_nxt;
   end

   // ---------------- loop FSM ----------------
   always_comb begin
      lstate_nxt = lstate;
      quit       = 1'b0;
      case (lstate)
         L_IDLE: begin
            if (loop_start) begin
               if (loop_done && loop_continue) quit       = 1'b1;
               else                            lstate_nxt = L_ACTIVE;
            end
         end
         L_ACTIVE: begin
            if (loop_done && loop_continue) begin
               quit       = 1'b1;
               lstate_nxt = L_IDLE;
            end
         end
         default: lstate_nxt = L_IDLE;
      endcase
   end

   assign quit_match   = (cur_state == quit_state) & quit_enable & ~quit_block;
   assign loop_cnt_nxt = quit ? sat_inc(loop_count) : loop_count;

   // inflight check on quit uses the post-update count so a retire in the
   // quit cycle itself is credited
   always_comb begin
      err_nxt = quit_error;
      if (quit && ((quit_at_end && inflight_nxt != '0) || !quit_match)) err_nxt = 1'b1;
      if (end_ev && inflight == '0)                                     err_nxt = 1'b1;
      if (ap_ready && mstate == M_IDLE && !ap_start)                    err_nxt = 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mstate           <= M_IDLE;
         lstate           <= L_IDLE;
         lat_cnt          <= '0;
         txn_count        <= '0;
         lat_last         <= '0;
         lat_max          <= '0;
         iter_start_count <= '0;
         iter_end_count   <= '0;
         stall_count      <= '0;
         loop_count       <= '0;
         quit_error       <= 1'b0;
         finished         <= 1'b0;
      end else if (!finished) begin
         mstate           <= mstate_nxt;
         lstate           <= lstate_nxt;
         lat_cnt          <= lat_cnt_nxt;
         txn_count        <= txn_nxt;
         lat_last         <= lat_last_nxt;
         lat_max          <= lat_max_nxt;
         iter_start_count <= start_nxt;
         iter_end_count   <= end_nxt;
         stall_count      <= stall_nxt;
         loop_count       <= loop_cnt_nxt;
         quit_error       <= err_nxt;
         finished         <= finish;
      end
   end

   assign module_busy = (mstate != M_IDLE);
   assign loop_active = (lstate == L_ACTIVE);
   assign inflight    = iter_start_count - iter_end_count;

endmodule

// File: tb/tb_loop_activity_monitor.sv
// Directed bench for loop_activity_monitor; narrow counters expose saturation.
module tb_loop_activity_monitor;

   localparam int STATE_W = 2;
   localparam int CNT_W   = 4;

   logic clock = 1'b0;
   logic reset;
   logic ap_start, ap_ready, ap_done, ap_continue, finish;
   logic [STATE_W-1:0] cur_state, iter_start_state, iter_end_state, quit_state;
   logic iter_start_block, iter_end_block, quit_block;
   logic iter_start_enable, iter_end_enable, quit_enable;
   logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;
   logic module_busy, loop_active, quit_error, finished;
   logic [CNT_W-1:0] txn_count, lat_last, lat_max, iter_start_count, iter_end_count;
   logic [CNT_W-1:0] stall_count, loop_count, inflight;

   int checks = 0;
   int errors = 0;

   logic [14:0] start_sched, stall_sched, end_sched;

   always #5 clock = ~clock;

   loop_activity_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
      .finish(finish), .cur_state(cur_state),
      .iter_start_state(iter_start_state), .iter_end_state(iter_end_state), .quit_state(quit_state),
      .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
      .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
      .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
      .loop_continue(loop_continue), .quit_at_end(quit_at_end),
      .module_busy(module_busy), .loop_active(loop_active),
      .txn_count(txn_count), .lat_last(lat_last), .lat_max(lat_max),
      .iter_start_count(iter_start_count), .iter_end_count(iter_end_count),
      .stall_count(stall_count), .loop_count(loop_count), .inflight(inflight),
      .quit_error(quit_error), .finished(finished)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
      iter_start_block = 0; iter_end_block = 0; quit_block = 0;
      iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
      loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      reset = 1'b0;
      cur_state = 2'd1; iter_start_state = 2'd1; iter_end_state = 2'd1; quit_state = 2'd1;
      quit_at_end = 1'b1;
      repeat (3) tick();

      chk("rst_busy",     module_busy, 0);
      chk("rst_lactive",  loop_active, 0);
      chk("rst_txn",      txn_count, 0);
      chk("rst_latmax",   lat_max, 0);
      chk("rst_istart",   iter_start_count, 0);
      chk("rst_qerr",     quit_error, 0);
      chk("rst_finished", finished, 0);

      // reset in the middle of a transaction discards it
      reset = 1'b1; tick();
      ap_start = 1; tick(); ap_start = 0; tick();
      chk("mid_busy", module_busy, 1);
      reset = 1'b0; #1;
      chk("mid_rst_busy", module_busy, 0);
      reset = 1'b1; tick();
      chk("mid_rst_txn", txn_count, 0);

      // single transaction: done 5 cycles after start -> latency 6
      ap_start = 1; tick(); ap_start = 0;
      repeat (4) tick();
      chk("t1_busy", module_busy, 1);
      ap_done = 1; tick(); ap_done = 0;
      chk("t1_txn",     txn_count, 1);
      chk("t1_latlast", lat_last, 6);
      chk("t1_latmax",  lat_max, 6);
      chk("t1_idle",    module_busy, 0);

      // start and done together -> latency 1, max kept
      ap_start = 1; ap_done = 1; tick(); ap_start = 0; ap_done = 0;
      chk("t2_txn",     txn_count, 2);
      chk("t2_latlast", lat_last, 1);
      chk("t2_latmax",  lat_max, 6);

      // ap_continue held low after done
      ap_start = 1; tick(); ap_start = 0; tick();
      ap_done = 1; ap_continue = 0; tick(); ap_done = 0;
      chk("t3_latlast", lat_last, 3);
      chk("t3_txn_wait", txn_count, 2);
      repeat (3) tick();
      chk("t3_busy_wait", module_busy, 1);
      chk("t3_txn_wait2", txn_count, 2);
      ap_continue = 1; tick();
      chk("t3_txn",  txn_count, 3);
      chk("t3_idle", module_busy, 0);

      // latency of 22 saturates the 4-bit counters at 15
      ap_start = 1; tick(); ap_start = 0;
      repeat (20) tick();
      ap_done = 1; tick(); ap_done = 0;
      chk("t4_latlast_sat", lat_last, 15);
      chk("t4_latmax_sat",  lat_max, 15);
      chk("t4_txn",         txn_count, 4);

      // pipelined loop: 10 iterations, depth 2, 3 stall cycles
      start_sched = 15'b001_1101_1100_1111;
      stall_sched = 15'b000_0010_0011_0000;
      end_sched   = 15'b111_0111_0011_1100;
      loop_start = 1; tick(); loop_start = 0;
      chk("lp_active", loop_active, 1);
      for (int c = 0; c < 15; c++) begin
         iter_start_enable = start_sched[c] | stall_sched[c];
         iter_start_block  = stall_sched[c];
         iter_end_enable   = end_sched[c];
         if (c == 14) begin
            loop_done = 1; loop_continue = 1; quit_enable = 1;
         end
         tick();
         if (c == 4) chk("lp_inflight_mid", inflight, 1);
      end
      clear_inputs();
      chk("lp_istart",   iter_start_count, 10);
      chk("lp_iend",     iter_end_count, 10);
      chk("lp_stall",    stall_count, 3);
      chk("lp_loops",    loop_count, 1);
      chk("lp_qerr",     quit_error, 0);
      chk("lp_inactive", loop_active, 0);
      chk("lp_inflight", inflight, 0);

      // early quit with two iterations still in flight
      do_reset();
      loop_start = 1; tick(); loop_start = 0;
      iter_start_enable = 1; repeat (2) tick(); iter_start_enable = 0;
      loop_done = 1; loop_continue = 1; quit_enable = 1; tick();
      clear_inputs();
      chk("eq_inflight", inflight, 2);
      chk("eq_qerr",     quit_error, 1);
      chk("eq_loops",    loop_count, 1);
      chk("eq_inactive", loop_active, 0);

      // ap_ready alongside ap_start is legal; ap_ready alone in idle is not
      do_reset();
      ap_start = 1; ap_ready = 1; ap_done = 1; tick(); clear_inputs();
      chk("rdy_ok_qerr", quit_error, 0);
      ap_ready = 1; tick(); ap_ready = 0;
      chk("rdy_bad_qerr", quit_error, 1);

      // retire with nothing in flight
      do_reset();
      chk("ee_qerr_clr", quit_error, 0);
      iter_end_enable = 1; tick(); iter_end_enable = 0;
      chk("ee_qerr", quit_error, 1);

      // finish freezes everything from the following cycle on
      do_reset();
      loop_start = 1; tick(); loop_start = 0;
      iter_start_enable = 1; tick();
      chk("fin_istart1", iter_start_count, 1);
      finish = 1; tick(); finish = 0;
      chk("fin_finished", finished, 1);
      chk("fin_istart2",  iter_start_count, 2);
      repeat (2) tick();
      iter_start_enable = 0;
      ap_start = 1; tick(); ap_start = 0;
      chk("fin_istart_frozen", iter_start_count, 2);
      chk("fin_busy_frozen",   module_busy, 0);
      chk("fin_still",         finished, 1);
      chk("fin_lactive",       loop_active, 1);

      // transaction counter saturates
      do_reset();
      ap_start = 1; ap_done = 1;
      repeat (15) tick();
      chk("sat_txn15", txn_count, 15);
      repeat (2) tick();
      clear_inputs();
      chk("sat_txn_hold", txn_count, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
